// File: rtl/uart_cmd_decoder_if.sv
// Receive-side link between the UART receive stage and the command decoder.
// Handshake: the receive stage presents a byte on rx_data and raises rx_done;
// the decoder takes exactly one byte per rising edge of rx_done, so a strobe
// held high for several cycles still delivers a single byte. There is no
// back-pressure: the decoder always consumes the byte on the cycle it is seen.
// dbg_state mirrors the decoder FSM (0 = IDLE, 1 = NUM) for observation.
interface uart_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       dbg_state;

    modport master (output rx_data, output rx_done, input dbg_state);
    modport slave  (input rx_data, input rx_done, output dbg_state);
endinterface

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder driving a counter: r/m/c toggle run, toggle mode and
// pulse clear; 's' followed by up to MAX_DIGITS decimal digits and CR/LF loads
// a saturated preset value. A numeric entry is aborted after TIMEOUT_CYC idle
// cycles. Optional macro CMD_CASE_INSENSITIVE_EN makes R/M/C/S act like r/m/c/s.
module uart_cmd_decoder #(
    parameter int VAL_W       = 14,
    parameter int MAX_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_cmd_decoder_if.slave    rx,
    output logic                 o_run,
    output logic                 o_mode,
    output logic                 o_clear,
    output logic                 o_load,
    output logic [VAL_W-1:0]     o_load_val,
    output logic                 o_err
);
    localparam int ACC_W = VAL_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DIGITS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ACC_W-1:0] VAL_MAX  = {4'b0000, {VAL_W{1'b1}}};

    localparam logic [7:0] CH_R  = 8'h72;
    localparam logic [7:0] CH_M  = 8'h6D;
    localparam logic [7:0] CH_C  = 8'h63;
    localparam logic [7:0] CH_S  = 8'h73;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_SP = 8'h20;

    typedef enum logic {IDLE = 1'b0, NUM = 1'b1} state_t;

    state_t             state, state_n;
    logic               rx_done_q;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [TMO_W-1:0]   tmo, tmo_n;
    logic               run_n, mode_n, clear_n, load_n, err_n;
    logic [VAL_W-1:0]   load_val_n;

    logic               accept;
    logic [7:0]         byte_in;
    logic               is_digit;
    logic [ACC_W-1:0]   acc_next;

    assign accept       = rx.rx_done & ~rx_done_q;
    assign rx.dbg_state = (state == NUM);
    assign is_digit     = (byte_in >= 8'h30) && (byte_in <= 8'h39);
    assign acc_next     = (acc * ACC_W'(10)) + {{(ACC_W-4){1'b0}}, byte_in[3:0]};

    // Fold uppercase command letters onto lowercase when the option is built in.
    always_comb begin
        byte_in = rx.rx_data;
`ifdef CMD_CASE_INSENSITIVE_EN
        if (rx.rx_data == 8'h52 || rx.rx_data == 8'h4D ||
            rx.rx_data == 8'h43 || rx.rx_data == 8'h53)
            byte_in = rx.rx_data | 8'h20;
`endif
    end

    // Next-state and next-output decode; every register holds unless changed.
    always_comb begin
        state_n    = state;
        run_n      = o_run;
        mode_n     = o_mode;
        load_val_n = o_load_val;
        clear_n    = 1'b0;
        load_n     = 1'b0;
        err_n      = 1'b0;
        acc_n      = acc;
        cnt_n      = cnt;
        tmo_n      = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (byte_in)
                        CH_R: run_n   = ~o_run;
                        CH_M: mode_n  = ~o_mode;
                        CH_C: clear_n = 1'b1;
                        CH_S: begin
                            acc_n   = '0;
                            cnt_n   = '0;
                            state_n = NUM;
                        end
                        CH_CR, CH_LF, CH_SP: ;
                        default: err_n = 1'b1;
                    endcase
                end
            end
            NUM: begin
                if (accept) begin
                    // An accepted byte always wins over a coincident timeout.
                    if (is_digit) begin
                        if (cnt == CNT_MAX) begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            acc_n = acc_next;
                            cnt_n = cnt + 1'b1;
                        end
                    end else if (byte_in == CH_CR || byte_in == CH_LF) begin
                        state_n = IDLE;
                        if (cnt != '0) begin
                            load_n     = 1'b1;
                            load_val_n = (acc > VAL_MAX) ? {VAL_W{1'b1}} : acc[VAL_W-1:0];
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (tmo == TMO_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset discards any partial entry silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rx_done_q  <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            tmo        <= '0;
            o_run      <= 1'b0;
            o_mode     <= 1'b0;
            o_clear    <= 1'b0;
            o_load     <= 1'b0;
            o_err      <= 1'b0;
            o_load_val <= '0;
        end else begin
            state      <= state_n;
            rx_done_q  <= rx.rx_done;
            acc        <= acc_n;
            cnt        <= cnt_n;
            tmo        <= tmo_n;
            o_run      <= run_n;
            o_mode     <= mode_n;
            o_clear    <= clear_n;
            o_load     <= load_n;
            o_err      <= err_n;
            o_load_val <= load_val_n;
        end
    end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder (VAL_W=12 so a 4-digit entry can saturate).
module tb_uart_cmd_decoder;
    localparam int VAL_W = 12;
    localparam int TMO   = 50;

    typedef struct {
        logic [7:0]       data;
        logic             run, mode, clr, ld, err, st;
        logic [VAL_W-1:0] val;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic o_run, o_mode, o_clear, o_load, o_err;
    logic [VAL_W-1:0] o_load_val;
    int total = 0;
    int bad = 0;
    vec_t tbl[$];

    uart_cmd_decoder_if rx_if ();

    uart_cmd_decoder #(.VAL_W(VAL_W), .MAX_DIGITS(4), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx_if),
        .o_run(o_run), .o_mode(o_mode), .o_clear(o_clear), .o_load(o_load),
        .o_load_val(o_load_val), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] d, input logic run, input logic mode, input logic clr,
                       input logic ld, input logic err, input logic st, input int val);
        vec_t v;
        v.data = d; v.run = run; v.mode = mode; v.clr = clr;
        v.ld = ld; v.err = err; v.st = st; v.val = VAL_W'(val);
        tbl.push_back(v);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rise.
    task automatic send_byte(input logic [7:0] b);
        rx_if.rx_data = b;
        rx_if.rx_done = 1'b1;
        @(negedge clk);
        rx_if.rx_done = 1'b0;
    endtask

    initial begin
        int first;
        int nerr;
        int nclr;
        rx_if.rx_data = 8'h00;
        rx_if.rx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_run", o_run, 0);
        check("reset_mode", o_mode, 0);
        check("reset_clear", o_clear, 0);
        check("reset_load", o_load, 0);
        check("reset_err", o_err, 0);
        check("reset_val", o_load_val, 0);
        check("reset_state", rx_if.dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        //  data   run mode clr ld err st val
        add(8'h72, 1, 0, 0, 0, 0, 0, 0);     // r
        add(8'h6D, 1, 1, 0, 0, 0, 0, 0);     // m
        add(8'h72, 0, 1, 0, 0, 0, 0, 0);     // r
        add(8'h63, 0, 1, 1, 0, 0, 0, 0);     // c
        add(8'h20, 0, 1, 0, 0, 0, 0, 0);     // space ignored
        add(8'h78, 0, 1, 0, 0, 1, 0, 0);     // x unknown
        add(8'h73, 0, 1, 0, 0, 0, 1, 0);     // s
        add(8'h31, 0, 1, 0, 0, 0, 1, 0);
        add(8'h32, 0, 1, 0, 0, 0, 1, 0);
        add(8'h33, 0, 1, 0, 0, 0, 1, 0);
        add(8'h34, 0, 1, 0, 0, 0, 1, 0);
        add(8'h0D, 0, 1, 0, 1, 0, 0, 1234); // CR loads 1234
        add(8'h73, 0, 1, 0, 0, 0, 1, 1234);
        add(8'h31, 0, 1, 0, 0, 0, 1, 1234);
        add(8'h32, 0, 1, 0, 0, 0, 1, 1234);
        add(8'h33, 0, 1, 0, 0, 0, 1, 1234);
        add(8'h34, 0, 1, 0, 0, 0, 1, 1234);
        add(8'h35, 0, 1, 0, 0, 1, 0, 1234); // fifth digit aborts
        add(8'h73, 0, 1, 0, 0, 0, 1, 1234);
        add(8'h0A, 0, 1, 0, 0, 1, 0, 1234); // LF with no digits
        add(8'h73, 0, 1, 0, 0, 0, 1, 1234);
        add(8'h39, 0, 1, 0, 0, 0, 1, 1234);
        add(8'h39, 0, 1, 0, 0, 0, 1, 1234);
        add(8'h39, 0, 1, 0, 0, 0, 1, 1234);
        add(8'h39, 0, 1, 0, 0, 0, 1, 1234);
        add(8'h0A, 0, 1, 0, 1, 0, 0, 4095); // 9999 saturates
        add(8'h73, 0, 1, 0, 0, 0, 1, 4095);
        add(8'h37, 0, 1, 0, 0, 0, 1, 4095);
        add(8'h71, 0, 1, 0, 0, 1, 0, 4095); // q aborts entry
        add(8'h0A, 0, 1, 0, 0, 0, 0, 4095); // LF ignored in IDLE
        add(8'h72, 1, 1, 0, 0, 0, 0, 4095);
        add(8'h73, 1, 1, 0, 0, 0, 1, 4095);
        add(8'h30, 1, 1, 0, 0, 0, 1, 4095);
        add(8'h0D, 1, 1, 0, 1, 0, 0, 0);    // loads 0

        foreach (tbl[i]) begin
            send_byte(tbl[i].data);
            check($sformatf("v%0d_run", i), o_run, tbl[i].run);
            check($sformatf("v%0d_mode", i), o_mode, tbl[i].mode);
            check($sformatf("v%0d_clear", i), o_clear, tbl[i].clr);
            check($sformatf("v%0d_load", i), o_load, tbl[i].ld);
            check($sformatf("v%0d_err", i), o_err, tbl[i].err);
            check($sformatf("v%0d_state", i), rx_if.dbg_state, tbl[i].st);
            check($sformatf("v%0d_val", i), o_load_val, tbl[i].val);
            @(negedge clk);
        end

        // Uppercase R: toggles run only when the case-folding option is built in.
        send_byte(8'h52);
`ifdef CMD_CASE_INSENSITIVE_EN
        check("upper_r_run", o_run, 0);
        check("upper_r_err", o_err, 0);
`else
        check("upper_r_run", o_run, 1);
        check("upper_r_err", o_err, 1);
`endif
        @(negedge clk);

        // Timeout: 's' then silence; error expected TMO cycles after acceptance.
        send_byte(8'h73);
        first = 0;
        nerr = 0;
        for (int k = 1; k <= TMO + 10; k++) begin
            @(negedge clk);
            if (o_err) begin
                nerr++;
                if (first == 0) first = k;
            end
        end
        check("timeout_cycle", first, TMO);
        check("timeout_count", nerr, 1);
        check("timeout_state", rx_if.dbg_state, 0);
        send_byte(8'h63);
        check("after_timeout_clear", o_clear, 1);
        @(negedge clk);

        // Byte arriving on the expiry cycle wins over the timeout.
        send_byte(8'h73);
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'h35);
        check("tmo_race_err", o_err, 0);
        check("tmo_race_state", rx_if.dbg_state, 1);
        @(negedge clk);
        send_byte(8'h0D);
        check("tmo_race_load", o_load, 1);
        check("tmo_race_val", o_load_val, 5);
        @(negedge clk);

        // rx_done held high for 5 cycles gives a single clear.
        nclr = 0;
        rx_if.rx_data = 8'h63;
        rx_if.rx_done = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (o_clear) nclr++;
        end
        rx_if.rx_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_clear) nclr++;
        end
        check("held_done_clears", nclr, 1);

        // Reset mid-entry discards the partial value without pulses.
        send_byte(8'h73);
        @(negedge clk);
        send_byte(8'h31);
        rst_n = 1'b0;
        #1;
        check("midrst_state", rx_if.dbg_state, 0);
        check("midrst_val", o_load_val, 0);
        check("midrst_run", o_run, 0);
        nerr = 0;
        repeat (2) begin
            @(negedge clk);
            if (o_err || o_load) nerr++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h0D);
        check("midrst_cr_load", o_load, 0);
        check("midrst_cr_err", o_err, 0);
        check("midrst_pulses", nerr, 0);
        @(negedge clk);
        send_byte(8'h35);
        check("midrst_idle_digit_err", o_err, 1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
